// File: rtl/plb_cache_responder.sv
// Fully-associative permission lookup cache answering PLB walker requests.
// Optional hit/miss counters are compiled in with `define PLB_CACHE_STATS_EN.
module plb_cache_responder #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    plb_cache_mem_req,
    output logic                    plb_cache_mem_gnt,
    output logic                    plb_cache_mem_valid,
    input  logic [ADDR_WIDTH-1:0]   plb_cache_mem_addr,
    input  logic                    plb_cache_mem_we,
    input  logic [DATA_WIDTH/8-1:0] plb_cache_mem_be,
    input  logic [DATA_WIDTH-1:0]   plb_cache_mem_wdata,
    output logic [DATA_WIDTH-1:0]   plb_cache_mem_rdata,
    output logic                    plb_cache_mem_error
`ifdef PLB_CACHE_STATS_EN
    ,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
`endif
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [ADDR_WIDTH-1:0]  key_q  [NUM_ENTRIES];
    logic [6:0]             perm_q [NUM_ENTRIES];
    logic [IDX_W-1:0]       rr_q;

    logic                   grant;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   has_free;
    logic [IDX_W-1:0]       free_idx;
    logic                   do_refill;
    logic                   be_zero;
    logic [IDX_W-1:0]       wr_idx;
    logic [DATA_WIDTH-1:0]  rdata_d;
    logic                   unused_wdata;

    // Flops never see rst_i on their data path; the output gate covers reset.
    assign grant             = plb_cache_mem_req & ~flush_i;
    assign plb_cache_mem_gnt = grant & ~rst_i;

    // Descending scan leaves the lowest matching/free index selected.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == plb_cache_mem_addr) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign be_zero   = ~|plb_cache_mem_be;
    assign do_refill = grant & plb_cache_mem_we & ~be_zero;

    always_comb begin
        wr_idx = rr_q;
        if (hit) begin
            wr_idx = hit_idx;
        end else if (has_free) begin
            wr_idx = free_idx;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (!plb_cache_mem_we && hit) begin
            rdata_d[7:0] = {perm_q[hit_idx], 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else if (do_refill) begin
            valid_q[wr_idx] <= 1'b1;
            if (!hit && !has_free) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_refill) begin
            key_q[wr_idx]  <= plb_cache_mem_addr;
            perm_q[wr_idx] <= plb_cache_mem_wdata[7:1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            plb_cache_mem_valid <= 1'b0;
            plb_cache_mem_rdata <= '0;
            plb_cache_mem_error <= 1'b0;
        end else begin
            plb_cache_mem_valid <= grant;
            if (grant) begin
                plb_cache_mem_rdata <= rdata_d;
                plb_cache_mem_error <= plb_cache_mem_we & be_zero;
            end
        end
    end

    assign unused_wdata = ^plb_cache_mem_wdata;

`ifdef PLB_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (grant && !plb_cache_mem_we) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: doc/plb_cache_responder.md
PLB_CACHE_RESPONDER -- requirements
Module: plb_cache_responder

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of fully-associative entries, power of two, 2..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: lookup key width (width of plb_lookup_req_t).
REQ-003 SHALL have parameter DATA_WIDTH, default 8: response width (PLB_TRANSACTION_DATA_WIDTH).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i, input, 1 bit: invalidate all entries.
REQ-007 SHALL have port plb_cache_mem_req, input, 1 bit: request from the walker.
REQ-008 SHALL have port plb_cache_mem_gnt, output, 1 bit: request accepted.
REQ-009 SHALL have port plb_cache_mem_valid, output, 1 bit: response valid.
REQ-010 SHALL have port plb_cache_mem_addr, input, ADDR_WIDTH bits: lookup or refill key.
REQ-011 SHALL have port plb_cache_mem_we, input, 1 bit: 1 = refill, 0 = lookup.
REQ-012 SHALL have port plb_cache_mem_be, input, DATA_WIDTH/8 bits: byte enable for refill.
REQ-013 SHALL have port plb_cache_mem_wdata, input, DATA_WIDTH bits: refill payload; bit 0 is ignored and bits [7:1] are permissions.
REQ-014 SHALL have port plb_cache_mem_rdata, output, DATA_WIDTH bits: bit 0 = hit, bits [7:1] = permissions of the hit entry.
REQ-015 SHALL have port plb_cache_mem_error, output, 1 bit: response error, qualified by valid.

Function
REQ-016 Each entry SHALL hold a valid bit, an ADDR_WIDTH key and 7 permission bits.
REQ-017 gnt SHALL equal req AND NOT flush_i, combinationally; every granted request SHALL be accepted, one per cycle, with no stalls.
REQ-018 valid SHALL assert exactly one cycle after each grant, with rdata and error registered from the grant cycle.
REQ-019 Lookup: on a matching valid key, rdata SHALL be {perm, 1'b1}; on a miss, rdata SHALL be 8'h00.
REQ-020 Lookup SHALL see array state before the grant-cycle edge; a refill granted in cycle N SHALL be visible to a lookup granted in cycle N+1.
REQ-021 Refill with be != 0 and the key already present SHALL update that entry's permissions in place, so no duplicate keys exist.
REQ-022 Refill with be != 0 and a new key SHALL write the lowest-index invalid entry.
REQ-023 If all entries are valid, a refill SHALL write the entry at the round-robin pointer, then increment the pointer modulo NUM_ENTRIES (wrap NUM_ENTRIES-1 -> 0).
REQ-024 Every refill response SHALL return rdata = 8'h00.
REQ-025 A refill with be == 0 SHALL not modify any state and SHALL respond with error = 1.
REQ-026 All other responses SHALL have error = 0.
REQ-027 flush_i SHALL clear all valid bits and the round-robin pointer at the next edge.
REQ-028 A response already in flight when flush_i rises SHALL still be delivered unchanged.
REQ-029 When req and flush_i are both high, flush SHALL win: gnt = 0, and the requester holds req.
REQ-030 When req = 0, valid SHALL deassert in the following cycle; rdata and error SHALL hold their last values.

Reset
REQ-031 rst_i high SHALL asynchronously clear all valid bits, the round-robin pointer, valid, rdata (8'h00) and error (0).
REQ-032 While rst_i is high, gnt SHALL be 0.
REQ-033 Keys and permissions SHALL not require reset.
REQ-034 A request granted in the cycle rst_i asserts SHALL be dropped, with no response after reset.

Configuration
REQ-035 With macro PLB_CACHE_STATS_EN defined, the block SHALL add output hit_count_o (32 bits) and output miss_count_o (32 bits).
REQ-036 With PLB_CACHE_STATS_EN defined, each lookup response SHALL increment the matching counter, saturating at 32'hFFFF_FFFF.
REQ-037 With PLB_CACHE_STATS_EN defined, both counters SHALL be cleared by rst_i only, not by flush_i.
REQ-038 Without PLB_CACHE_STATS_EN, those ports and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-039 Bench SHALL cover: refill key 0x1000, wdata 8'hAE, be 1; then lookup 0x1000 -> next cycle valid = 1, rdata = 8'hAF, error = 0.
REQ-040 Bench SHALL cover: lookup 0x2000 on an empty cache -> rdata = 8'h00, valid = 1 one cycle after gnt.
REQ-041 Bench SHALL cover: 9 refills of distinct keys (NUM_ENTRIES = 8) -> entry 0 is evicted, so lookup of the first key misses and the 9th key hits; a 10th refill evicts entry 1.
REQ-042 Bench SHALL cover: refill with be = 0 -> error = 1, and a subsequent lookup of that key misses.
REQ-043 Bench SHALL cover: req and flush_i high together -> gnt = 0; a lookup held on the next cycle misses; an in-flight response from before the flush is unaffected.
REQ-044 Bench SHALL cover: with PLB_CACHE_STATS_EN, 3 hits and 2 misses -> hit_count_o = 3, miss_count_o = 2, and both are unchanged after flush_i.
